// File: rtl/axi_dma_pkg.sv
// Shared AXI constants, DMA write-path FSM encoding and a width helper.
package axi_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned AXI_4KB = 4096;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } wr_state_e;

  // Bit width needed to index v entries, never less than one.
  function automatic int unsigned clog2_w(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/burst_len_fifo.sv
// Synchronous FIFO holding {beats, tail strobe} for AW-accepted bursts awaiting W data.
module burst_len_fifo
  import axi_dma_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 13
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = clog2_w(Depth);
  localparam int unsigned CntW = clog2_w(Depth + 1);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot, so a push is still accepted when full.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/axi_burst_write_master.sv
// AXI4 write master: splits a byte-length transfer into INCR bursts and streams FIFO data.
module axi_burst_write_master
  import axi_dma_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MAX_BURST_BEATS  = 16,
  parameter int unsigned C_MAX_OUTSTANDING  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_dst_addr,
  input  logic [31:0]                     i_total_len,
  output logic                            o_busy,
  output logic                            o_write_done,
  output logic                            o_error,
  input  logic                            i_fifo_empty,
  output logic                            o_fifo_rd_en,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_w_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic [2:0]                      m_axi_awsize,
  output logic [1:0]                      m_axi_awburst,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  localparam int unsigned AW     = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned BYTES  = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned BYTE_W = $clog2(BYTES);
  localparam int unsigned QW     = 9 + BYTES;
  localparam int unsigned OUT_W  = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [12:0] MAX_BYTES = 13'(C_MAX_BURST_BEATS * BYTES);
  localparam logic [12:0] BOUNDARY  = 13'(AXI_4KB);

  wr_state_e        state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      rem_q, rem_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             error_q, error_d;
  logic             done_q, done_d;

  logic             awvalid_q, awvalid_d;
  logic [AW-1:0]    awaddr_q, awaddr_d;
  logic [7:0]       awlen_q, awlen_d;
  logic [12:0]      aw_bytes_q, aw_bytes_d;
  logic [8:0]       aw_beats_q, aw_beats_d;
  logic [BYTES-1:0] aw_strb_q, aw_strb_d;

  logic             w_active_q, w_active_d;
  logic [8:0]       w_beat_q, w_beat_d;
  logic [8:0]       w_beats_q, w_beats_d;
  logic [BYTES-1:0] w_strb_q, w_strb_d;

  logic [12:0]      to_4k, max_or_4k, burst_bytes;
  logic [8:0]       burst_beats;
  logic [BYTE_W-1:0] tail_rem;
  logic [BYTES-1:0] burst_strb;

  logic             aw_hs, w_hs, b_hs, w_last, wvalid;
  logic             q_pop, q_full, q_empty;
  logic [QW-1:0]    q_rdata;

  // Burst size is the tightest of remaining bytes, max burst and distance to 4KB.
  always_comb begin
    to_4k       = BOUNDARY - {1'b0, addr_q[11:0]};
    max_or_4k   = (to_4k < MAX_BYTES) ? to_4k : MAX_BYTES;
    burst_bytes = (rem_q < {19'd0, max_or_4k}) ? rem_q[12:0] : max_or_4k;
    burst_beats = 9'((burst_bytes + 13'(BYTES - 1)) >> BYTE_W);
    tail_rem    = burst_bytes[BYTE_W-1:0];
    for (int unsigned i = 0; i < BYTES; i++) begin
      burst_strb[i] = (tail_rem == '0) || (BYTE_W'(i) < tail_rem);
    end
  end

  assign aw_hs = awvalid_q && m_axi_awready;
  assign b_hs  = m_axi_bvalid && m_axi_bready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    error_d    = error_q;
    done_d     = 1'b0;
    awvalid_d  = awvalid_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    aw_bytes_d = aw_bytes_q;
    aw_beats_d = aw_beats_q;
    aw_strb_d  = aw_strb_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          error_d = 1'b0;
          if (i_dst_addr[BYTE_W-1:0] != '0) begin
            error_d = 1'b1;
            done_d  = 1'b1;
          end else if (i_total_len == 32'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = i_dst_addr;
            rem_d   = i_total_len;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (aw_hs) begin
          addr_d    = addr_q + AW'(aw_bytes_q);
          rem_d     = rem_q - 32'(aw_bytes_q);
          awvalid_d = 1'b0;
          if (rem_q == 32'(aw_bytes_q)) begin
            state_d = StDrain;
          end
        end else if (!awvalid_q && rem_q != 32'd0 &&
                     outstanding_q < OUT_W'(C_MAX_OUTSTANDING) && !q_full) begin
          awvalid_d  = 1'b1;
          awaddr_d   = addr_q;
          awlen_d    = 8'(burst_beats - 9'd1);
          aw_bytes_d = burst_bytes;
          aw_beats_d = burst_beats;
          aw_strb_d  = burst_strb;
        end
      end
      StDrain: begin
        if (outstanding_q == '0 && !w_active_q && q_empty) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (b_hs && m_axi_bresp != AXI_RESP_OKAY) begin
      error_d = 1'b1;
    end
    outstanding_d = outstanding_q + OUT_W'(aw_hs) - OUT_W'(b_hs);
  end

  // W engine: loads one queued burst at a time, independent of the AW side.
  assign wvalid = w_active_q && !i_fifo_empty;
  assign w_hs   = wvalid && m_axi_wready;
  assign w_last = w_active_q && (w_beat_q == w_beats_q - 9'd1);

  always_comb begin
    w_active_d = w_active_q;
    w_beat_d   = w_beat_q;
    w_beats_d  = w_beats_q;
    w_strb_d   = w_strb_q;
    q_pop      = 1'b0;
    if (!w_active_q) begin
      if (!q_empty) begin
        q_pop      = 1'b1;
        w_active_d = 1'b1;
        w_beat_d   = '0;
        w_beats_d  = q_rdata[QW-1:BYTES];
        w_strb_d   = q_rdata[BYTES-1:0];
      end
    end else if (w_hs) begin
      if (w_last) begin
        w_active_d = 1'b0;
      end else begin
        w_beat_d = w_beat_q + 9'd1;
      end
    end
  end

  burst_len_fifo #(
    .Depth (C_MAX_OUTSTANDING),
    .Width (QW)
  ) u_burst_q (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (aw_hs),
    .wdata_i ({aw_beats_q, aw_strb_q}),
    .pop_i   (q_pop),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      rem_q         <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
      done_q        <= 1'b0;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      aw_bytes_q    <= '0;
      aw_beats_q    <= '0;
      aw_strb_q     <= '0;
      w_active_q    <= 1'b0;
      w_beat_q      <= '0;
      w_beats_q     <= '0;
      w_strb_q      <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
      done_q        <= done_d;
      awvalid_q     <= awvalid_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      aw_bytes_q    <= aw_bytes_d;
      aw_beats_q    <= aw_beats_d;
      aw_strb_q     <= aw_strb_d;
      w_active_q    <= w_active_d;
      w_beat_q      <= w_beat_d;
      w_beats_q     <= w_beats_d;
      w_strb_q      <= w_strb_d;
    end
  end

  assign o_busy        = (state_q != StIdle);
  assign o_write_done  = done_q;
  assign o_error       = error_q;
  assign o_fifo_rd_en  = w_hs;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  // Fixed AW fields are only driven alongside awvalid so every output idles at zero.
  assign m_axi_awsize  = awvalid_q ? 3'(BYTE_W) : 3'd0;
  assign m_axi_awburst = awvalid_q ? AXI_BURST_INCR : 2'b00;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid;
  assign m_axi_wdata   = wvalid ? i_w_data : '0;
  assign m_axi_wlast   = w_last;
  assign m_axi_wstrb   = !w_active_q ? '0 : (w_last ? w_strb_q : '1);
  assign m_axi_bready  = (state_q == StRun) || (state_q == StDrain);

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Scoreboard bench: expected AW/W/done events are queued at stimulus time, a monitor pops them.
module tb_axi_burst_write_master;

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_exp_t;
  typedef struct { logic last; logic [3:0] strb; } w_exp_t;
  typedef struct { int bcnt; logic err; } done_exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start;
  logic [31:0] i_dst_addr;
  logic [31:0] i_total_len;
  logic        o_busy, o_write_done, o_error, i_fifo_empty, o_fifo_rd_en;
  logic [31:0] i_w_data, m_axi_awaddr, m_axi_wdata;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst, m_axi_bresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;

  // Second instance at 64-bit data width.
  logic        d64_start, d64_busy, d64_done, d64_error, d64_rd_en;
  logic [31:0] d64_awaddr;
  logic [7:0]  d64_awlen;
  logic [2:0]  d64_awsize;
  logic [1:0]  d64_awburst;
  logic        d64_awvalid, d64_wlast, d64_wvalid, d64_bvalid, d64_bready;
  logic [63:0] d64_wdata;
  logic [7:0]  d64_wstrb;

  aw_exp_t   aw_exp[$];
  w_exp_t    w_exp[$];
  done_exp_t done_exp[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, word_cnt = 0, aw_hs_cnt = 0, b_pending = 0, b_cnt = 0, done_seen = 0;
  int b_allow = 1 << 30, err_idx = -1;
  int d64_pend = 0, d64_beats = 0, d64_done_seen = 0;
  logic stall_en = 1'b0;
  logic aw_hold = 1'b0;
  logic [31:0] hold_addr;
  logic [7:0]  hold_len;

  always #5 clk = ~clk;

  axi_burst_write_master u_dut (
    .clk (clk), .reset_n (reset_n), .i_start (i_start), .i_dst_addr (i_dst_addr),
    .i_total_len (i_total_len), .o_busy (o_busy), .o_write_done (o_write_done),
    .o_error (o_error), .i_fifo_empty (i_fifo_empty), .o_fifo_rd_en (o_fifo_rd_en),
    .i_w_data (i_w_data), .m_axi_awaddr (m_axi_awaddr), .m_axi_awlen (m_axi_awlen),
    .m_axi_awsize (m_axi_awsize), .m_axi_awburst (m_axi_awburst),
    .m_axi_awvalid (m_axi_awvalid), .m_axi_awready (m_axi_awready),
    .m_axi_wdata (m_axi_wdata), .m_axi_wstrb (m_axi_wstrb), .m_axi_wlast (m_axi_wlast),
    .m_axi_wvalid (m_axi_wvalid), .m_axi_wready (m_axi_wready), .m_axi_bresp (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid), .m_axi_bready (m_axi_bready)
  );

  axi_burst_write_master #(.C_M_AXI_DATA_WIDTH (64)) u_dut64 (
    .clk (clk), .reset_n (reset_n), .i_start (d64_start), .i_dst_addr (32'h100),
    .i_total_len (32'd10), .o_busy (d64_busy), .o_write_done (d64_done),
    .o_error (d64_error), .i_fifo_empty (1'b0), .o_fifo_rd_en (d64_rd_en),
    .i_w_data (64'h0123_4567_89AB_CDEF), .m_axi_awaddr (d64_awaddr), .m_axi_awlen (d64_awlen),
    .m_axi_awsize (d64_awsize), .m_axi_awburst (d64_awburst),
    .m_axi_awvalid (d64_awvalid), .m_axi_awready (1'b1),
    .m_axi_wdata (d64_wdata), .m_axi_wstrb (d64_wstrb), .m_axi_wlast (d64_wlast),
    .m_axi_wvalid (d64_wvalid), .m_axi_wready (1'b1), .m_axi_bresp (2'b00),
    .m_axi_bvalid (d64_bvalid), .m_axi_bready (d64_bready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not expected or never seen (t=%0t)", name, $time);
  endtask

  task automatic push_burst(input logic [31:0] addr, input logic [7:0] len,
                            input int beats, input logic [3:0] tail);
    aw_exp.push_back('{addr: addr, len: len});
    for (int i = 0; i < beats; i++) begin
      w_exp.push_back('{last: (i == beats - 1), strb: (i == beats - 1) ? tail : 4'hF});
    end
  endtask

  task automatic push_done(input int bcnt, input logic err);
    done_exp.push_back('{bcnt: bcnt, err: err});
  endtask

  task automatic start_xfer(input logic [31:0] dst, input logic [31:0] len);
    i_dst_addr  = dst;
    i_total_len = len;
    i_start     = 1'b1;
    @(posedge clk); #1;
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int base;
    base = done_seen;
    for (int i = 0; i < max_cyc && done_seen == base; i++) begin
      @(posedge clk); #1;
    end
    if (done_seen == base) fail({name, "_timeout"});
    check({name, "_aw_left"}, aw_exp.size(), 0);
    check({name, "_w_left"}, w_exp.size(), 0);
  endtask

  // Slave/FIFO driver: updates inputs just after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      m_axi_awready = (cyc % 3 != 0);
      m_axi_wready  = (cyc % 4 != 1);
      i_fifo_empty  = stall_en && (cyc % 3 == 1);
      i_w_data      = 32'hA500_0000 | word_cnt;
      m_axi_bvalid  = (b_pending > 0) && (b_allow > 0);
      m_axi_bresp   = (b_cnt == err_idx) ? 2'b10 : 2'b00;
      d64_bvalid    = (d64_pend > 0);
    end
  end

  // Monitor: values at the falling edge are what the next rising edge samples.
  always @(negedge clk) begin : mon
    aw_exp_t   ae;
    w_exp_t    we;
    done_exp_t de;
    if (reset_n) begin
      if (aw_hold) begin
        check("aw_stable_valid", m_axi_awvalid, 1);
        check("aw_stable_addr", m_axi_awaddr, hold_addr);
        check("aw_stable_len", m_axi_awlen, hold_len);
      end
      aw_hold   = m_axi_awvalid && !m_axi_awready;
      hold_addr = m_axi_awaddr;
      hold_len  = m_axi_awlen;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_hs_cnt++;
        if (aw_exp.size() == 0) fail("aw_unexpected");
        else begin
          ae = aw_exp.pop_front();
          check("awaddr", m_axi_awaddr, ae.addr);
          check("awlen", m_axi_awlen, ae.len);
          check("awsize", m_axi_awsize, 3'd2);
          check("awburst", m_axi_awburst, 2'b01);
        end
      end
      if (i_fifo_empty) begin
        check("wvalid_while_empty", m_axi_wvalid, 0);
        check("rd_en_while_empty", o_fifo_rd_en, 0);
      end
      if (m_axi_wvalid || o_fifo_rd_en)
        check("rd_en", o_fifo_rd_en, m_axi_wvalid && m_axi_wready);
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_exp.size() == 0) fail("w_unexpected");
        else begin
          we = w_exp.pop_front();
          check("wlast", m_axi_wlast, we.last);
          check("wstrb", m_axi_wstrb, we.strb);
          check("wdata", m_axi_wdata, 32'hA500_0000 | word_cnt);
        end
        word_cnt++;
        if (m_axi_wlast) b_pending++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pending--;
        b_allow--;
        b_cnt++;
      end
      if (o_write_done) begin
        done_seen++;
        if (done_exp.size() == 0) fail("done_unexpected");
        else begin
          de = done_exp.pop_front();
          check("done_b_count", b_cnt, de.bcnt);
          check("done_error", o_error, de.err);
          check("done_busy_low", o_busy, 0);
        end
        b_cnt = 0;
      end
      if (d64_awvalid) begin
        check("d64_awaddr", d64_awaddr, 32'h100);
        check("d64_awlen", d64_awlen, 8'd1);
        check("d64_awsize", d64_awsize, 3'd3);
      end
      if (d64_wvalid) begin
        d64_beats++;
        if (d64_wlast) begin
          check("d64_beats", d64_beats, 2);
          check("d64_wstrb", d64_wstrb, 8'h03);
          d64_pend++;
        end
      end
      if (d64_bvalid && d64_bready) d64_pend--;
      if (d64_done) d64_done_seen++;
    end
  end

  initial begin
    int base;
    reset_n = 1'b0;
    i_start = 1'b0; i_dst_addr = '0; i_total_len = '0; d64_start = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    i_fifo_empty = 1'b0; i_w_data = '0; d64_bvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_write_done, 0);
    check("rst_error", o_error, 0);
    check("rst_awaddr", m_axi_awaddr, 0);
    check("rst_wstrb", m_axi_wstrb, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 256 bytes from 0: four full 16-beat bursts.
    for (int k = 0; k < 4; k++) push_burst(32'(k * 64), 8'd15, 16, 4'hF);
    push_done(4, 1'b0);
    start_xfer(32'h0, 32'd256);
    check("busy_after_start", o_busy, 1);
    wait_done("len256", 3000);

    // 4KB boundary split.
    push_burst(32'hFF0, 8'd3, 4, 4'hF);
    push_burst(32'h1000, 8'd11, 12, 4'hF);
    push_done(2, 1'b0);
    start_xfer(32'hFF0, 32'd64);
    wait_done("cross4k", 3000);

    // 10 bytes: partial final beat.
    push_burst(32'h2000, 8'd2, 3, 4'b0011);
    push_done(1, 1'b0);
    start_xfer(32'h2000, 32'd10);
    wait_done("len10", 1000);

    // 64-bit instance, 10 bytes.
    d64_start = 1'b1;
    @(posedge clk); #1;
    d64_start = 1'b0;
    for (int i = 0; i < 200 && d64_done_seen == 0; i++) begin
      @(posedge clk); #1;
    end
    check("d64_done_seen", d64_done_seen, 1);
    check("d64_error", d64_error, 0);

    // Outstanding limit with B withheld.
    b_allow = 0;
    for (int k = 0; k < 16; k++) push_burst(32'h3000 + 32'(k * 64), 8'd15, 16, 4'hF);
    push_done(16, 1'b0);
    base = aw_hs_cnt;
    start_xfer(32'h3000, 32'd1024);
    repeat (300) @(posedge clk);
    #1;
    check("outstanding_cap", aw_hs_cnt - base, 4);
    check("awvalid_blocked", m_axi_awvalid, 0);
    b_allow = 1;
    repeat (100) @(posedge clk);
    #1;
    check("one_more_aw", aw_hs_cnt - base, 5);
    b_allow = 1 << 30;
    wait_done("outstanding", 5000);

    // SLVERR on the second of three bursts.
    err_idx = 1;
    for (int k = 0; k < 3; k++) push_burst(32'h4000 + 32'(k * 64), 8'd15, 16, 4'hF);
    push_done(3, 1'b1);
    start_xfer(32'h4000, 32'd192);
    wait_done("bresp_err", 3000);
    check("error_sticky", o_error, 1);
    err_idx = -1;

    // Zero length: done next cycle, error cleared.
    push_done(0, 1'b0);
    start_xfer(32'h5000, 32'd0);
    check("len0_done", o_write_done, 1);
    check("len0_error", o_error, 0);
    check("len0_awvalid", m_axi_awvalid, 0);
    repeat (5) @(posedge clk);
    #1;

    // Misaligned start.
    push_done(0, 1'b1);
    start_xfer(32'h5002, 32'd8);
    check("misalign_done", o_write_done, 1);
    check("misalign_error", o_error, 1);
    repeat (5) @(posedge clk);
    #1;

    // FIFO empty stalls.
    stall_en = 1'b1;
    push_burst(32'h6000, 8'd15, 16, 4'hF);
    push_done(1, 1'b0);
    start_xfer(32'h6000, 32'd64);
    wait_done("stall", 3000);

    // Reset mid-burst.
    for (int k = 0; k < 4; k++) push_burst(32'h7000 + 32'(k * 64), 8'd15, 16, 4'hF);
    start_xfer(32'h7000, 32'd256);
    repeat (30) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_awvalid", m_axi_awvalid, 0);
    check("midrst_wvalid", m_axi_wvalid, 0);
    check("midrst_rd_en", o_fifo_rd_en, 0);
    check("midrst_bready", m_axi_bready, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_wlast", m_axi_wlast, 0);
    check("midrst_awlen", m_axi_awlen, 0);
    aw_exp.delete();
    w_exp.delete();
    done_exp.delete();
    b_pending = 0;
    b_cnt = 0;
    aw_hold = 1'b0;
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_busy", o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_burst_write_master.md
Name: axi_burst_write_master

Overview:
Parametrised AXI4-Full write master that drains an internal stream FIFO to memory. It is the next generation of the DMA write path. It adds:
- Configurable data width and maximum burst length.
- Multiple outstanding bursts, with AW issue decoupled from W data.
- Byte-granular transfer lengths, using WSTRB on the final beat.
- BRESP error reporting.

It sits between the DMA controller's FIFO and the AXI interconnect.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, address width.
C_M_AXI_DATA_WIDTH, 32, data width in bits: 32, 64 or 128. BYTES = C_M_AXI_DATA_WIDTH/8.
C_MAX_BURST_BEATS, 16, maximum beats per burst: power of two, 1 to 256.
C_MAX_OUTSTANDING, 4, maximum AW-accepted bursts without a B response: power of two, 1 to 16.

Ports:
clk  in  1  system clock. Single clock domain; reset_n is asynchronous, active-low.
reset_n  in  1  asynchronous active-low reset.
i_start  in  1  start pulse; ignored while o_busy=1.
i_dst_addr  in  ADDR  start address; must be BYTES-aligned.
i_total_len  in  32  transfer length in bytes; 0 is legal.
o_busy  out  1  high from the cycle after an accepted start until the done pulse.
o_write_done  out  1  one-cycle pulse when all B responses have been received.
o_error  out  1  sticky; set by any non-OKAY BRESP or a misaligned start; cleared by an accepted start.
i_fifo_empty  in  1  FIFO empty flag.
o_fifo_rd_en  out  1  equals wvalid && wready.
i_w_data  in  DATA  FIFO output data (first-word-fall-through).
m_axi_awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awvalid  out; m_axi_awready  in.
m_axi_wdata  out  DATA; m_axi_wstrb  out  BYTES; m_axi_wlast, m_axi_wvalid  out; m_axi_wready  in.
m_axi_bresp  in  2; m_axi_bvalid  in; m_axi_bready  out.

Behaviour:
- Reset values: every output is 0. This includes awvalid, wvalid, bready, o_busy, o_write_done and o_error. All counters and the queue are cleared.
- Reset mid-operation abandons the transfer immediately; the interconnect is reset alongside.
- Fixed AW fields: awsize = log2(BYTES); awburst = INCR.
- Main FSM: IDLE -> RUN -> DRAIN -> IDLE.
- IDLE:
  - i_start with len=0: o_write_done pulses on the next cycle; no AXI traffic.
  - i_start with misaligned i_dst_addr: o_error=1 and o_write_done pulses; no AXI traffic.
  - Otherwise: latch address and remaining bytes, then go to RUN.
- Burst sizing, evaluated in RUN:
  - bytes = min(remaining, C_MAX_BURST_BEATS*BYTES, 4KB boundary - addr).
  - beats = ceil(bytes/BYTES); awlen = beats-1.
  - tail strobe = low (bytes mod BYTES) bits set, or all ones when the remainder is 0.
- awvalid is registered. It is asserted when all of the following hold: in RUN, remaining>0, outstanding<C_MAX_OUTSTANDING, and the queue is not full.
  - Once asserted, awaddr, awlen and awvalid stay stable until awready.
- On AW handshake:
  - Push {beats, tail strobe} into the burst queue.
  - addr += bytes; remaining -= bytes; outstanding++.
  - When remaining reaches 0, go to DRAIN.
- W engine, independent of the FSM:
  - Pop the queue head and run that burst's beats.
  - wvalid = entry active && !i_fifo_empty.
  - wlast on beat beats-1.
  - wstrb is all ones except on the final beat of the final burst, which carries the tail strobe.
  - An empty FIFO stalls the engine with wvalid=0; beats are counted only on handshake.
  - The next entry is popped in the cycle after wlast is accepted.
- B channel:
  - bready=1 in RUN and DRAIN.
  - Each handshake decrements outstanding and ORs (bresp!=OKAY) into o_error.
  - A simultaneous AW handshake and B handshake leaves outstanding unchanged.
- DRAIN -> IDLE when outstanding=0 and the W engine is idle. o_write_done pulses on the transition cycle and o_busy falls with it.
- Error handling: the transfer always completes to the final B. There is no early abort.

Decomposition:
- Shared package axi_dma_pkg holds:
  - AXI_BURST_INCR and AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - AXI_4KB = 4096.
  - FSM state encodings.
  - The clog2-based width helper.
- One sub-module: burst_len_fifo. It is a synchronous FIFO of depth C_MAX_OUTSTANDING and width 9+BYTES, with full/empty flags and a simultaneous push/pop allowed when full.

Test Plan:
- DATA=32, BEATS=16; dst=0x0000_0000, len=256 -> 4 bursts with awlen=15 at 0x00/0x40/0x80/0xC0; each wlast on beat 16; o_write_done pulses once; o_error=0.
- dst=0x0000_0FF0, len=64 -> first burst addr 0xFF0 awlen=3; second burst addr 0x1000 awlen=11; no burst crosses 4KB.
- len=10 (DATA=32) -> one burst awlen=2; beat 3 has wlast=1 and wstrb=4'b0011. With DATA=64, len=10 -> awlen=1, last wstrb=8'h03.
- OUTSTANDING=4, len=1024, bvalid held low -> exactly 4 AW handshakes, then awvalid=0. Releasing one B -> exactly one further AW.
- 3 bursts, bresp=2'b10 on the second -> o_error=1, and o_write_done pulses after the third B. i_start with len=0 -> done pulse next cycle, o_error cleared, no awvalid.
- i_fifo_empty toggled mid-burst, plus reset_n asserted mid-burst -> wvalid=0 and rd_en=0 while empty, with no beat counted. Reset returns all outputs to 0 immediately, and o_busy=0.
